// File: rtl/addr_region_decoder_pkg.sv
// Shared types and default memory map for the multi-region address decoder.
package addr_region_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERROR  = 2'd2
    } state_t;

    localparam logic [31:0] DMEM_BASE  = 32'h0000_0780;
    localparam logic [31:0] DMEM_LIMIT = 32'h0000_0B7F;
    localparam logic [31:0] IMEM_LIMIT = 32'h0000_077F;

    // Width of a region index; a single region still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addr_region_decoder_region_match.sv
// Combinational priority comparator: lowest-index region containing addr wins.
module region_match
    import addr_region_decoder_pkg::*;
#(
    parameter int unsigned                ADDR_W = 32,
    parameter int unsigned                N_REG  = 2,
    parameter int unsigned                WS_W   = 4,
    parameter logic [N_REG*ADDR_W-1:0]    BASE   = {32'h0000_0780, 32'h0000_0000},
    parameter logic [N_REG*ADDR_W-1:0]    LIMIT  = {32'h0000_0B7F, 32'h0000_077F},
    parameter logic [N_REG*WS_W-1:0]      WAITS  = {4'd2, 4'd0}
) (
    input  logic [ADDR_W-1:0]        addr,
    output logic                     hit,
    output logic [idx_w(N_REG)-1:0]  idx,
    output logic [ADDR_W-1:0]        offset,
    output logic [WS_W-1:0]          waits
);

    for (genvar g = 0; g < N_REG; g++) begin : g_chk
        if (BASE[g*ADDR_W +: ADDR_W] > LIMIT[g*ADDR_W +: ADDR_W]) begin : g_bad
            $fatal(1, "region %0d: BASE above LIMIT", g);
        end
    end

    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        offset = '0;
        waits  = '0;
        for (int unsigned k = 0; k < N_REG; k++) begin
            if (!hit && addr >= BASE[k*ADDR_W +: ADDR_W] && addr <= LIMIT[k*ADDR_W +: ADDR_W]) begin
                hit    = 1'b1;
                idx    = idx_w(N_REG)'(k);
                offset = addr - BASE[k*ADDR_W +: ADDR_W];
                waits  = WAITS[k*WS_W +: WS_W];
            end
        end
    end

endmodule

// File: rtl/addr_region_decoder.sv
// Registered multi-region address decoder with per-region wait states.
module addr_region_decoder
    import addr_region_decoder_pkg::*;
#(
    parameter int unsigned                ADDR_W = 32,
    parameter int unsigned                N_REG  = 2,
    parameter int unsigned                WS_W   = 4,
    parameter logic [N_REG*ADDR_W-1:0]    BASE   = {DMEM_BASE, 32'h0000_0000},
    parameter logic [N_REG*ADDR_W-1:0]    LIMIT  = {DMEM_LIMIT, IMEM_LIMIT},
    parameter logic [N_REG*WS_W-1:0]      WAITS  = {4'd2, 4'd0}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              WE,
    input  logic [ADDR_W-1:0] inputResult,
    output logic              req_ready,
    output logic [N_REG-1:0]  CS,
    output logic [ADDR_W-1:0] iAddress,
    output logic              iWE,
    output logic              ack,
    output logic              err
);

    localparam int unsigned IW = idx_w(N_REG);

    logic              m_hit;
    logic [IW-1:0]     m_idx;
    logic [ADDR_W-1:0] m_off;
    logic [WS_W-1:0]   m_waits;

    region_match #(
        .ADDR_W (ADDR_W),
        .N_REG  (N_REG),
        .WS_W   (WS_W),
        .BASE   (BASE),
        .LIMIT  (LIMIT),
        .WAITS  (WAITS)
    ) u_match (
        .addr   (inputResult),
        .hit    (m_hit),
        .idx    (m_idx),
        .offset (m_off),
        .waits  (m_waits)
    );

    state_t            state, state_n;
    logic [WS_W-1:0]   cnt, cnt_n;
    logic              we_l, we_n;
    logic              rdy_n, iwe_n, ack_n, err_n;
    logic [N_REG-1:0]  cs_n;
    logic [ADDR_W-1:0] addr_n;

    // Outputs are registered from the next-state decode, so each state's
    // outputs are visible during the cycle the FSM occupies that state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        we_n    = we_l;
        rdy_n   = 1'b0;
        cs_n    = '0;
        addr_n  = '0;
        iwe_n   = 1'b0;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                rdy_n = 1'b1;
                if (req) begin
                    rdy_n = 1'b0;
                    we_n  = WE;
                    if (m_hit) begin
                        state_n      = ACCESS;
                        cnt_n        = m_waits;
                        cs_n[m_idx]  = 1'b1;
                        addr_n       = m_off;
                        ack_n        = (m_waits == '0);
                        iwe_n        = WE && (m_waits == '0);
                    end else begin
                        state_n = ERROR;
                        ack_n   = 1'b1;
                        err_n   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    rdy_n   = 1'b1;
                    we_n    = 1'b0;
                end else begin
                    cnt_n  = cnt - 1'b1;
                    cs_n   = CS;
                    addr_n = iAddress;
                    ack_n  = (cnt == WS_W'(1));
                    iwe_n  = we_l && (cnt == WS_W'(1));
                end
            end
            ERROR: begin
                state_n = IDLE;
                rdy_n   = 1'b1;
                we_n    = 1'b0;
            end
            default: begin
                state_n = IDLE;
                rdy_n   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_l      <= 1'b0;
            req_ready <= 1'b1;
            CS        <= '0;
            iAddress  <= '0;
            iWE       <= 1'b0;
            ack       <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            we_l      <= we_n;
            req_ready <= rdy_n;
            CS        <= cs_n;
            iAddress  <= addr_n;
            iWE       <= iwe_n;
            ack       <= ack_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_addr_region_decoder.sv
// Directed self-checking bench for addr_region_decoder (default map plus an overlap map).
module tb_addr_region_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, WE;
    logic [31:0] inputResult;
    logic        req_ready, iWE, ack, err;
    logic [1:0]  CS;
    logic [31:0] iAddress;

    logic        req2, WE2;
    logic [31:0] addr2;
    logic        rdy2, iwe2, ack2, err2;
    logic [1:0]  cs2;
    logic [31:0] iaddr2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    addr_region_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .WE          (WE),
        .inputResult (inputResult),
        .req_ready   (req_ready),
        .CS          (CS),
        .iAddress    (iAddress),
        .iWE         (iWE),
        .ack         (ack),
        .err         (err)
    );

    // Region 0 = 0x100..0x1FF, region 1 = 0x000..0x1FF: both cover 0x100..0x1FF.
    addr_region_decoder #(
        .BASE  ({32'h0000_0000, 32'h0000_0100}),
        .LIMIT ({32'h0000_01FF, 32'h0000_01FF}),
        .WAITS ({4'd0, 4'd0})
    ) dut_ovl (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req2),
        .WE          (WE2),
        .inputResult (addr2),
        .req_ready   (rdy2),
        .CS          (cs2),
        .iAddress    (iaddr2),
        .iWE         (iwe2),
        .ack         (ack2),
        .err         (err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] cs, input logic [31:0] ia,
                           input logic we, input logic ak, input logic er, input logic rd);
        chk({tag, ".CS"},        {30'd0, CS},        {30'd0, cs});
        chk({tag, ".iAddress"},  iAddress,           ia);
        chk({tag, ".iWE"},       {31'd0, iWE},       {31'd0, we});
        chk({tag, ".ack"},       {31'd0, ack},       {31'd0, ak});
        chk({tag, ".err"},       {31'd0, err},       {31'd0, er});
        chk({tag, ".req_ready"}, {31'd0, req_ready}, {31'd0, rd});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; WE = 1'b0; inputResult = '0;
        req2 = 1'b0; WE2 = 1'b0; addr2 = '0;
        step(); step();
        chk_out("reset", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step();

        // Region 0, zero wait states
        req = 1'b1; WE = 1'b1; inputResult = 32'h0000_0010;
        step();
        req = 1'b0;
        chk_out("r0_write", 2'b01, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("r0_idle", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Region 1 base, read, WAITS=2
        req = 1'b1; WE = 1'b0; inputResult = 32'h0000_0780;
        step();
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("r1_base_c%0d", i), 2'b10, 32'h0, 1'b0, (i == 2), 1'b0, 1'b0);
            step();
        end
        chk_out("r1_base_idle", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Region 1 limit, write strobe only in final cycle
        req = 1'b1; WE = 1'b1; inputResult = 32'h0000_0B7F;
        step();
        req = 1'b0; WE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("r1_lim_c%0d", i), 2'b10, 32'h3FF, (i == 2), (i == 2), 1'b0, 1'b0);
            step();
        end
        chk_out("r1_lim_idle", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Unmapped: just past region 1, then top of address space
        req = 1'b1; WE = 1'b1; inputResult = 32'h0000_0B80;
        step();
        req = 1'b0;
        chk_out("miss_b80", 2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_out("miss_b80_idle", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        req = 1'b1; WE = 1'b1; inputResult = 32'hFFFF_FFFF;
        step();
        req = 1'b0;
        chk_out("miss_top", 2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_out("miss_top_idle", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Busy: request held with new address while access in flight
        req = 1'b1; WE = 1'b0; inputResult = 32'h0000_0800;
        step();
        inputResult = 32'h0000_0010;
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("busy_c%0d", i), 2'b10, 32'h80, 1'b0, (i == 2), 1'b0, 1'b0);
            step();
        end
        chk_out("busy_gap", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        req = 1'b0;
        chk_out("busy_second", 2'b01, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0);
        step();

        // Overlap priority on the alternate map
        req2 = 1'b1; WE2 = 1'b0; addr2 = 32'h0000_0150;
        step();
        req2 = 1'b0;
        chk("ovl.CS",       {30'd0, cs2},  32'h1);
        chk("ovl.iAddress", iaddr2,        32'h50);
        chk("ovl.ack",      {31'd0, ack2}, 32'h1);
        chk("ovl.err",      {31'd0, err2}, 32'h0);
        step();

        // Asynchronous reset in the middle of a waited access
        req = 1'b1; WE = 1'b1; inputResult = 32'h0000_0900;
        step();
        req = $urandom_range(0, 1); WE = $urandom_range(0, 1); inputResult = $urandom;
        chk_out("pre_abort", 2'b10, 32'h180, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("abort_async", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        req = 1'b1; WE = 1'b1; inputResult = 32'h0000_0400;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("held_rst_c%0d", i), 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        req = 1'b0;
        rst_n = 1'b1;
        step();
        chk_out("after_rst", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addr_region_decoder.md
Name: addr_region_decoder

Overview:
- Parametrised, registered successor to the single-window data-memory address decoder.
- Maps one bus master address onto N_REG memory/peripheral regions, each with its own base, limit and wait-state count.
- Generates a one-hot chip select, a region-relative address, a gated write enable, a completion ack and an unmapped-access error.
- Sits between the ALU/address path of the RISC core and the data memory and peripheral blocks.

Parameters:
ADDR_W, 32, address and offset width.
N_REG, 2, number of decoded regions (1..8).
WS_W, 4, width of each per-region wait-state field.
BASE, {32'h0000_0780, 32'h0000_0000}, packed N_REG*ADDR_W; region k base at bits [k*ADDR_W +: ADDR_W].
LIMIT, {32'h0000_0B7F, 32'h0000_077F}, packed N_REG*ADDR_W; inclusive upper bound per region.
WAITS, {4'd2, 4'd0}, packed N_REG*WS_W; extra cycles region k holds CS before completing.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req  in  1  master request; sampled only when req_ready=1.
WE  in  1  master write enable; qualified by req.
inputResult  in  ADDR_W  master byte address; qualified by req.
req_ready  out  1  1 in IDLE only; request accepted on clk edge where req & req_ready.
CS  out  N_REG  one-hot region select; all-zero when idle or unmapped.
iAddress  out  ADDR_W  inputResult minus BASE of the selected region; 0 when CS=0.
iWE  out  1  write strobe to the selected region.
ack  out  1  single-cycle completion pulse.
err  out  1  single-cycle unmapped-access flag, coincident with ack.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, CS=0, iAddress=0, iWE=0, ack=0, err=0, req_ready=1, wait counter=0, latched WE=0.
- Decode: hit_k = (addr >= BASE_k) && (addr <= LIMIT_k). Comparison is unsigned and bounds are inclusive. The lowest-index hit wins on overlap. At most one CS bit is ever set.
- Offset: addr - BASE_k, computed in ADDR_W bits. No overflow is possible on a hit.
- FSM states: IDLE, ACCESS, ERROR.
- IDLE:
  - req_ready=1; all other outputs 0.
  - On req=1: latch inputResult, WE, the region index and its WAITS value.
  - Any hit -> ACCESS, counter = WAITS_k.
  - No hit -> ERROR.
- ACCESS:
  - CS[k]=1 and iAddress=offset for every cycle in the state; req_ready=0.
  - Counter decrements each cycle while nonzero.
  - In the cycle the counter is 0: ack=1, iWE=latched WE, then -> IDLE.
  - Total ACCESS length is WAITS_k+1 cycles. iWE is asserted in the final cycle only, so a write is issued exactly once.
- ERROR: one cycle; ack=1, err=1, CS=0, iWE=0, iAddress=0; -> IDLE.
- Latency: accept edge to ack = WAITS_k+1 cycles for a hit, 1 cycle for a miss.
- Back-to-back: the earliest next accept is the cycle after ack. Minimum throughput is one access per 2 cycles.
- req while req_ready=0 is ignored and not queued; the master must hold req.
- Input changes on inputResult/WE after accept do not affect the access in flight.
- Reset asserted mid-access: all outputs clear immediately (asynchronously). No ack or iWE is produced for the aborted access.
- Address exactly BASE_k: offset 0. Address exactly LIMIT_k: hit. LIMIT_k+1 with no other covering region: err.
- All outputs are registered; there are no combinational paths from inputs to outputs except through state.
- Elaboration check: flag BASE_k > LIMIT_k as a fatal error.

Decomposition:
- Shared package: FSM state enum (IDLE/ACCESS/ERROR), region index width $clog2(N_REG) as a localparam function, default memory-map constants (DMEM_BASE=32'h780, DMEM_LIMIT=32'hB7F, IMEM_LIMIT=32'h77F).
- One sub-module is natural: region_match. It is a purely combinational priority comparator: addr in; hit, idx, offset, waits out. Instantiated once; the top holds the FSM, counter and output registers.

Test Plan:
1. Reset: assert rst_n=0 mid-simulation with random inputs -> CS=0, iWE=0, ack=0, err=0, req_ready=1 immediately. Drive req=1, WE=1, addr=32'h400 while rst_n=0 -> no ack.
2. Region 0, zero wait: req=1, WE=1, addr=32'h0000_0010 -> next cycle CS=2'b01, iAddress=32'h10, iWE=1, ack=1. The following cycle req_ready=1.
3. Region 1, boundaries with WAITS=2: addr=32'h780, WE=0 -> CS=2'b10 and iAddress=0 for 3 cycles, ack only in the 3rd, iWE=0 throughout. Repeat with addr=32'hB7F, WE=1 -> iAddress=32'h3FF, iWE=1 only in the 3rd cycle.
4. Unmapped: addr=32'hB80, WE=1 -> one cycle ack=1, err=1, CS=0, iWE=0. Repeat with addr=32'hFFFF_FFFF -> same response.
5. Busy/ignore: accept addr=32'h800. On the next cycle change addr to 32'h10 with req=1 -> the access in flight keeps iAddress=32'h80, and only one ack occurs. The second request is accepted the cycle after ack.
6. Overlap priority (override BASE/LIMIT so both regions cover 32'h100-32'h1FF): addr=32'h150 -> CS=2'b01, iAddress offset computed from region 0 base.
